// File: rtl/noc_pkg.sv
// Shared types for the NoC port buffer: flit type, read-side framing states
// and the packet queue type used by verification code.
package noc_pkg;

   localparam int FLIT_WIDTH_DEFAULT = 16;

   typedef logic [FLIT_WIDTH_DEFAULT-1:0] flit_t;

   typedef enum logic [1:0] {
      HEADER  = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } frame_state_t;

   typedef flit_t packet_t [$];

endpackage

// File: rtl/noc_fifo.sv
// First-word-fall-through storage with wrapping pointers and an occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module noc_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;

   always_comb begin
      wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_i) mem_q[wr_ptr_q] <= wdata_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is reset, so the head read is never X even when empty.
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/noc_port_buffer.sv
// One credit-based NoC input-port lane: FIFO plus read-side packet framing,
// delivered-packet counter and a sticky overrun flag.
module noc_port_buffer
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH = FLIT_WIDTH_DEFAULT,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       rx,
   input  logic [FLIT_WIDTH-1:0]      data_in,
   output logic                       credit_o,
   output logic                       tx,
   output logic [FLIT_WIDTH-1:0]      data_out,
   input  logic                       credit_i,
   output logic                       sop,
   output logic                       eop,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_WIDTH-1:0]       pkt_count,
   output logic                       proto_err
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic                  push, pop;
   frame_state_t          state_q, state_d;
   logic [FLIT_WIDTH-1:0] remain_q, remain_d;
   logic [CNT_WIDTH-1:0]  pkt_count_q;
   logic                  proto_err_q;

   assign credit_o = (occupancy != FULL_CNT);
   assign tx       = (occupancy != '0);
   assign push     = rx && credit_o;
   assign pop      = tx && credit_i;

   noc_fifo #(
      .W     (FLIT_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (data_in),
      .rdata_o (data_out),
      .count_o (occupancy)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= HEADER;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
      end
   end

   // Framing advances only on pops; the head flit drives all decisions.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      if (pop) begin
         unique case (state_q)
            HEADER: state_d = LEN;
            LEN: begin
               remain_d = data_out;
               state_d  = (data_out == '0) ? HEADER : PAYLOAD;
            end
            PAYLOAD: begin
               remain_d = remain_q - 1'b1;
               if (remain_q == FLIT_WIDTH'(1)) state_d = HEADER;
            end
            default: state_d = HEADER;
         endcase
      end
   end

   always_comb begin
      sop = 1'b0;
      eop = 1'b0;
      if (tx) begin
         unique case (state_q)
            HEADER:  sop = 1'b1;
            LEN:     eop = (data_out == '0);
            PAYLOAD: eop = (remain_q == FLIT_WIDTH'(1));
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pkt_count_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (pop && eop)      pkt_count_q <= pkt_count_q + 1'b1;
         if (rx && !credit_o) proto_err_q <= 1'b1;
      end
   end

   assign pkt_count = pkt_count_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_noc_port_buffer.sv
// Self-checking bench for noc_port_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based flit model.
module tb_noc_port_buffer;
   import noc_pkg::*;

   localparam int DEPTH = 8;
   localparam int FW    = 16;
   localparam int CW    = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          rx = 1'b0;
   logic          credit_i = 1'b0;
   logic [FW-1:0] data_in = '0;
   logic          credit_o, tx, sop, eop, proto_err;
   logic [FW-1:0] data_out;
   logic [$clog2(DEPTH):0] occupancy;
   logic [CW-1:0] pkt_count;

   noc_port_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .rx(rx), .data_in(data_in),
      .credit_o(credit_o), .tx(tx), .data_out(data_out), .credit_i(credit_i),
      .sop(sop), .eop(eop), .occupancy(occupancy), .pkt_count(pkt_count),
      .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   // Model: each stored flit carries the framing it must show at the head,
   // derived from its position in the pushed packet stream.
   typedef struct {
      logic [FW-1:0] data;
      bit            sop;
      bit            eop;
   } mflit_t;

   mflit_t  mq[$];
   int      m_pkt, m_idx, m_total;
   bit      m_err;
   packet_t src;
   int      n_tests, n_fail;

   typedef struct {
      bit            rx;
      logic [FW-1:0] d;
      bit            cr;
      int            occ;
      bit            tx;
      logic [FW-1:0] dout;
      bit            sop;
      bit            eop;
      int            pkt;
   } vec_t;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("occupancy", 32'(occupancy), mq.size());
      chk("tx", 32'(tx), 32'(mq.size() != 0));
      chk("credit_o", 32'(credit_o), 32'(mq.size() != DEPTH));
      chk("pkt_count", 32'(pkt_count), m_pkt % (1 << CW));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      if (mq.size() != 0) begin
         chk("data_out", 32'(data_out), 32'(mq[0].data));
         chk("sop", 32'(sop), 32'(mq[0].sop));
         chk("eop", 32'(eop), 32'(mq[0].eop));
      end else begin
         chk("sop_idle", 32'(sop), 0);
         chk("eop_idle", 32'(eop), 0);
      end
   endtask

   task automatic drive(bit r, logic [FW-1:0] d, bit c);
      rx = r; data_in = d; credit_i = c;
      @(negedge clock);
      model_check();
   endtask

   task automatic advance();
      bit     do_pop, do_push;
      mflit_t f;
      do_pop  = (mq.size() != 0) && credit_i;
      do_push = rx && (mq.size() != DEPTH);
      if (rx && mq.size() == DEPTH) m_err = 1'b1;
      @(posedge clock);
      #1;
      if (do_pop) begin
         f = mq.pop_front();
         if (f.eop) m_pkt++;
      end
      if (do_push) begin
         f.data = data_in;
         f.sop  = (m_idx == 0);
         if (m_idx == 1) m_total = int'(data_in) + 2;
         f.eop  = (m_idx == 1 && data_in == '0) || (m_idx >= 2 && m_idx == m_total - 1);
         m_idx  = f.eop ? 0 : m_idx + 1;
         mq.push_back(f);
      end
   endtask

   task automatic step(bit r, logic [FW-1:0] d, bit c);
      drive(r, d, c);
      advance();
   endtask

   task automatic do_reset();
      reset = 1'b0; rx = 1'b0; credit_i = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      mq.delete();
      src.delete();
      m_pkt = 0; m_err = 1'b0; m_idx = 0; m_total = 0;
   endtask

   task automatic gen_pkt(int len);
      src.push_back(FW'($urandom));
      src.push_back(FW'(len));
      for (int i = 0; i < len; i++) src.push_back(FW'($urandom));
   endtask

   // Offers the next source flit; it is retired only if the model accepts it.
   task automatic src_step(bit want, bit c);
      bit            acc;
      logic [FW-1:0] d;
      if (want && src.size() == 0) gen_pkt($urandom_range(0, 4));
      d = want ? src[0] : '0;
      drive(want, d, c);
      acc = want && (mq.size() != DEPTH);
      advance();
      if (acc) void'(src.pop_front());
   endtask

   vec_t tbl[7];

   initial begin
      n_tests = 0; n_fail = 0;
      tbl[0] = '{1'b1, 16'h0011, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b1, 16'h0003, 1'b1, 1, 1'b1, 16'h0011, 1'b1, 1'b0, 0};
      tbl[2] = '{1'b1, 16'h00A1, 1'b1, 1, 1'b1, 16'h0003, 1'b0, 1'b0, 0};
      tbl[3] = '{1'b1, 16'h00A2, 1'b1, 1, 1'b1, 16'h00A1, 1'b0, 1'b0, 0};
      tbl[4] = '{1'b1, 16'h00A3, 1'b1, 1, 1'b1, 16'h00A2, 1'b0, 1'b0, 0};
      tbl[5] = '{1'b0, 16'h0000, 1'b1, 1, 1'b1, 16'h00A3, 1'b0, 1'b1, 0};
      tbl[6] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 1'b0, 1};

      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
      chk("reset_data_out", 32'(data_out), 0);

      // Five-flit packet streamed straight through
      foreach (tbl[i]) begin
         drive(tbl[i].rx, tbl[i].d, tbl[i].cr);
         chk("vec_occ",  32'(occupancy), tbl[i].occ);
         chk("vec_tx",   32'(tx),        32'(tbl[i].tx));
         chk("vec_dout", 32'(data_out),  32'(tbl[i].dout));
         chk("vec_sop",  32'(sop),       32'(tbl[i].sop));
         chk("vec_eop",  32'(eop),       32'(tbl[i].eop));
         chk("vec_pkt",  32'(pkt_count), tbl[i].pkt);
         advance();
      end

      // Fill to full, overrun once, then drain in order
      step(1'b1, 16'h0033, 1'b0);
      step(1'b1, 16'h0006, 1'b0);
      for (int i = 1; i <= 6; i++) step(1'b1, FW'(16'h00B0 + i), 1'b0);
      chk("full_occ", 32'(occupancy), 8);
      chk("full_credit", 32'(credit_o), 0);
      step(1'b1, 16'h0055, 1'b0);
      chk("overrun_err", 32'(proto_err), 1);
      chk("overrun_occ", 32'(occupancy), 8);
      for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);
      chk("drain_pkt", 32'(pkt_count), 2);
      do_reset();
      drive(1'b0, '0, 1'b0);
      chk("err_cleared", 32'(proto_err), 0);
      advance();

      // Zero-length packet followed by another header
      step(1'b1, 16'h0022, 1'b0);
      step(1'b1, 16'h0000, 1'b0);
      step(1'b1, 16'h0044, 1'b0);
      step(1'b1, 16'h0001, 1'b0);
      step(1'b1, 16'h00BB, 1'b0);
      drive(1'b0, '0, 1'b1); chk("len0_hdr_sop", 32'(sop), 1); advance();
      drive(1'b0, '0, 1'b1); chk("len0_eop", 32'(eop), 1);     advance();
      drive(1'b0, '0, 1'b1); chk("next_hdr_sop", 32'(sop), 1); advance();
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      chk("len0_pkt", 32'(pkt_count), 2);

      // Steady stream at occupancy 3 across pointer wrap
      for (int i = 0; i < 3; i++) src_step(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         src_step(1'b1, 1'b1);
         chk("steady_occ", 32'(occupancy), 3);
      end
      while (src.size() != 0) src_step(1'b1, 1'b1);
      for (int i = 0; i < DEPTH; i++) src_step(1'b0, 1'b1);

      // Reset mid-packet at occupancy 4
      step(1'b1, 16'h0066, 1'b0);
      step(1'b1, 16'h0005, 1'b0);
      step(1'b1, 16'h00C1, 1'b0);
      step(1'b1, 16'h00C2, 1'b0);
      chk("pre_reset_occ", 32'(occupancy), 4);
      do_reset();
      drive(1'b1, 16'h0077, 1'b1);
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_tx", 32'(tx), 0);
      chk("rst_credit", 32'(credit_o), 1);
      advance();
      drive(1'b1, 16'h0001, 1'b1);
      chk("rst_hdr_sop", 32'(sop), 1);
      chk("rst_hdr_data", 32'(data_out), 32'h0077);
      advance();
      step(1'b1, 16'h00D1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      chk("rst_pkt", 32'(pkt_count), 1);

      // Randomized traffic with back-pressure and occasional overruns
      for (int i = 0; i < 600; i++)
         src_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      for (int i = 0; i < DEPTH + 2; i++) src_step(1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_port_buffer.md
Name: noc_port_buffer

Overview:
- Synthesizable, parametrised input-port buffer for the NoC router's credit-based port protocol (rx/data_in/credit_o in, tx/data_out/credit_i out).
- Each instance is one port lane.
- Adds configurable depth and flit width, packet framing (start/end-of-packet flags), an occupancy output, a delivered-packet counter and a protocol-violation flag.
- Sits between a neighbour router or the local IP core and the router's switch/arbitration logic.

Parameters:
- FLIT_WIDTH, 16, bits per flit.
- DEPTH, 8, buffer entries. Power of two, at least 2.
- CNT_WIDTH, 16, width of the packet counter. The counter wraps.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous reset, active-low (logic is reset when reset==0 at posedge clock).
- rx  in  1  upstream flit valid.
- data_in  in  FLIT_WIDTH  upstream flit.
- credit_o  out  1  buffer can accept a flit this cycle.
- tx  out  1  head flit valid.
- data_out  out  FLIT_WIDTH  head flit.
- credit_i  in  1  downstream accepts a flit this cycle.
- sop  out  1  head flit is a packet header.
- eop  out  1  head flit is the last flit of its packet.
- occupancy  out  $clog2(DEPTH)+1  entries currently stored.
- pkt_count  out  CNT_WIDTH  packets fully delivered downstream.
- proto_err  out  1  sticky: rx asserted while credit_o==0.

Behaviour:
- Packet format:
  - flit0 = header (target address).
  - flit1 = payload length N, unsigned, full FLIT_WIDTH.
  - flits 2..N+1 = payload.
  - Total flits = N+2. N=0 is legal (2-flit packet).
- Push: at posedge, when rx && credit_o, data_in is written at the write pointer. rx while credit_o==0: flit dropped, proto_err set to 1 and held until reset.
- credit_o = (occupancy != DEPTH). Combinational from the registered count.
- Pop (first-word-fall-through):
  - tx = (occupancy != 0). data_out = entry at the read pointer.
  - Pop happens at posedge when tx && credit_i.
  - data_out is X-free: it shows the last-written storage, storage reset to 0.
- Latency: a flit pushed at edge k is visible on tx/data_out after edge k (same-cycle pass-through is not required).
- Simultaneous push and pop:
  - Both happen and occupancy is unchanged.
  - Legal at any occupancy except full, where credit_o==0 blocks the push.
  - Empty with push: no pop, because tx==0.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Framing FSM on the read side, advancing only on pop:
  - HEADER: sop=1, eop=0. Pop -> LEN.
  - LEN: head is the length flit; remain <= head value. eop=1 if head==0. Pop -> HEADER if head==0, else PAYLOAD.
  - PAYLOAD: remain decrements on each pop. eop=1 when remain==1. Pop with remain==1 -> HEADER.
  - pkt_count increments on the pop where eop==1.
  - sop/eop are valid only when tx==1. They are forced 0 when tx==0.
  - remain is FLIT_WIDTH bits.
- Reset values:
  - occupancy=0, pointers=0, storage=0.
  - tx=0, credit_o=1, sop=0, eop=0.
  - FSM=HEADER, remain=0, pkt_count=0, proto_err=0.
- Reset mid-packet discards all stored flits and partial framing. The first flit pushed after reset is treated as a header.
- pkt_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Decomposition:
- Shared package noc_pkg:
  - FLIT_WIDTH default and the flit_t typedef.
  - The framing-state enum (HEADER, LEN, PAYLOAD).
  - The packet_t queue typedef used by the bench.
- One sub-module, noc_fifo: parametrised storage, pointers, occupancy.
- noc_port_buffer wraps noc_fifo and adds credit, framing FSM, counters and the error flag.

Test Plan:
- Reset, then idle for 5 cycles -> credit_o=1, tx=0, occupancy=0, pkt_count=0, proto_err=0.
- Push packet {0x0011, 0x0003, 0xA1, 0xA2, 0xA3} with credit_i=1 ->
  - tx rises the cycle after the first push.
  - sop=1 on 0x0011; eop=1 only on 0xA3.
  - pkt_count=1 after the eop pop.
- credit_i=0, push 9 flits with DEPTH=8 ->
  - occupancy=8 and credit_o=0 after the 8th push.
  - 9th rx sets proto_err=1 and occupancy stays 8.
  - Raising credit_i drains exactly 8 flits in order.
- Length-zero packet {0x0022, 0x0000} -> eop=1 on the length flit and the FSM returns to HEADER. A following header flit shows sop=1.
- Steady stream with rx=1 and credit_i=1 every cycle at occupancy 3 -> occupancy stays 3 through pointer wrap, and flit order is preserved.
- reset=0 mid-payload at occupancy 4, then release -> occupancy=0, tx=0, credit_o=1. The next packet frames correctly (sop on its first flit).
